// File: rtl/operand_unpacker_pkg.sv
// Shared types and elaboration-time helpers for the operand unpacker.
package operand_unpacker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EMIT  = 2'd2,
    DONE  = 2'd3
  } unpack_state_e;

  function automatic int unsigned calc_elems(input int unsigned word_w,
                                             input int unsigned elem_w);
    return word_w / elem_w;
  endfunction

  function automatic int unsigned calc_idx_w(input int unsigned elems);
    return (elems > 1) ? $clog2(elems) : 1;
  endfunction

endpackage

// File: rtl/sign_extender.sv
// Widens an element to OUT_WIDTH bits, replicating the MSB when signed_i is set.
module sign_extender #(
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned OUT_WIDTH = 16
) (
  input  logic [IN_WIDTH-1:0]  data_i,
  input  logic                 signed_i,
  output logic [OUT_WIDTH-1:0] data_o
);

  if (OUT_WIDTH > IN_WIDTH) begin : g_extend
    localparam int unsigned PAD_W = OUT_WIDTH - IN_WIDTH;
    assign data_o = {{PAD_W{signed_i & data_i[IN_WIDTH-1]}}, data_i};
  end else begin : g_pass
    assign data_o = data_i;
  end

endmodule

// File: rtl/operand_unpacker.sv
// Unpacks packed operand words into extended elements, one per output handshake.
// Optional one-word prefetch register: define OPERAND_UNPACKER_PREFETCH_EN.
module operand_unpacker
  import operand_unpacker_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned ELEM_WIDTH = 8,
  parameter int unsigned OUT_WIDTH  = 16,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cfg_valid_i,
  output logic                  cfg_ready_o,
  input  logic                  cfg_signed_i,
  input  logic [LEN_WIDTH-1:0]  cfg_len_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [WORD_WIDTH-1:0] in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [OUT_WIDTH-1:0]  out_data_o,
  output logic                  out_last_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int unsigned ELEMS = calc_elems(WORD_WIDTH, ELEM_WIDTH);
  localparam int unsigned IDX_W = calc_idx_w(ELEMS);

  unpack_state_e            state_q, state_d;
  logic [LEN_WIDTH-1:0]     remaining_q, remaining_d;
  logic [LEN_WIDTH-1:0]     words_left_q, words_left_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [WORD_WIDTH-1:0]    word_q, word_d;
  logic                     signed_q, signed_d;
`ifdef OPERAND_UNPACKER_PREFETCH_EN
  logic [WORD_WIDTH-1:0]    pf_word_q, pf_word_d;
  logic                     pf_valid_q, pf_valid_d;
`endif

  logic                     in_hs;
  logic [LEN_WIDTH:0]       len_round;
  logic [LEN_WIDTH-1:0]     words_init;
  logic [ELEMS-1:0][ELEM_WIDTH-1:0] word_elems;
  logic [OUT_WIDTH-1:0]     ext_data;

  // Word count is ceil(len/ELEMS); one extra bit keeps the rounding add from wrapping.
  assign len_round  = {1'b0, cfg_len_i} + (LEN_WIDTH+1)'(ELEMS - 1);
  assign words_init = LEN_WIDTH'(len_round / (LEN_WIDTH+1)'(ELEMS));

  // All handshake outputs decode registered state only.
  assign cfg_ready_o = (state_q == IDLE);
  assign out_valid_o = (state_q == EMIT);
  assign out_last_o  = out_valid_o && (remaining_q == LEN_WIDTH'(1));
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
`ifdef OPERAND_UNPACKER_PREFETCH_EN
  assign in_ready_o  = (state_q == FETCH) ||
                       ((state_q == EMIT) && !pf_valid_q && (words_left_q != '0));
`else
  assign in_ready_o  = (state_q == FETCH);
`endif
  assign in_hs = in_valid_i && in_ready_o;

  assign word_elems = word_q;

  sign_extender #(
    .IN_WIDTH  (ELEM_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_sign_extender (
    .data_i   (word_elems[idx_q]),
    .signed_i (signed_q),
    .data_o   (ext_data)
  );

  assign out_data_o = out_valid_o ? ext_data : '0;

  always_comb begin
    // NOTE: every _d gets its hold value first, so no path through the case infers a latch.
    state_d      = state_q;
    remaining_d  = remaining_q;
    words_left_d = words_left_q;
    idx_d        = idx_q;
    word_d       = word_q;
    signed_d     = signed_q;
`ifdef OPERAND_UNPACKER_PREFETCH_EN
    pf_word_d    = pf_word_q;
    pf_valid_d   = pf_valid_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (cfg_valid_i) begin
          signed_d     = cfg_signed_i;
          remaining_d  = cfg_len_i;
          words_left_d = words_init;
          idx_d        = '0;
          state_d      = (cfg_len_i == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (in_hs) begin
          word_d       = in_data_i;
          idx_d        = '0;
          words_left_d = words_left_q - LEN_WIDTH'(1);
          state_d      = EMIT;
        end
      end
      EMIT: begin
`ifdef OPERAND_UNPACKER_PREFETCH_EN
        if (in_hs) begin
          pf_word_d    = in_data_i;
          pf_valid_d   = 1'b1;
          words_left_d = words_left_q - LEN_WIDTH'(1);
        end
`endif
        if (out_ready_i) begin
          remaining_d = remaining_q - LEN_WIDTH'(1);
          idx_d       = idx_q + IDX_W'(1);
          if (remaining_q == LEN_WIDTH'(1)) begin
            state_d = DONE;
          end else if (idx_q == IDX_W'(ELEMS - 1)) begin
            idx_d = '0;
`ifdef OPERAND_UNPACKER_PREFETCH_EN
            // A word arriving on this same edge is used directly rather than parked.
            if (pf_valid_q) begin
              word_d     = pf_word_q;
              pf_valid_d = 1'b0;
            end else if (in_hs) begin
              word_d     = in_data_i;
              pf_valid_d = 1'b0;
            end else begin
              state_d = FETCH;
            end
`else
            state_d = FETCH;
`endif
          end
        end
      end
      DONE: begin
        state_d = IDLE;
`ifdef OPERAND_UNPACKER_PREFETCH_EN
        pf_valid_d = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments; the word registers are reset too so out_data_o is 0 from reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      words_left_q <= '0;
      idx_q        <= '0;
      word_q       <= '0;
      signed_q     <= 1'b0;
`ifdef OPERAND_UNPACKER_PREFETCH_EN
      pf_word_q    <= '0;
      pf_valid_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      words_left_q <= words_left_d;
      idx_q        <= idx_d;
      word_q       <= word_d;
      signed_q     <= signed_d;
`ifdef OPERAND_UNPACKER_PREFETCH_EN
      pf_word_q    <= pf_word_d;
      pf_valid_q   <= pf_valid_d;
`endif
    end
  end

endmodule
